serial_sub_ctrl: RTL and testbench

//   Bit-serial N-bit subtractor controller. Sequences one single-bit full-subtractor

---
 rtl/serial_sub_pkg.sv | 16 +
 rtl/serial_sub_ctrl_full_sub_bit.sv | 28 ++
 rtl/serial_sub_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_sub_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller: FSM state
// encoding and the bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Counter width needed to index WIDTH bits (0 .. WIDTH-1).
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_full_sub_bit.sv
// One-bit full subtractor built from two half subtractors and an OR.
// d = a ^ b ^ bin, bout = (~a & b) | (~(a ^ b) & bin).

module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bout
);
  assign d    = x ^ y;
  assign bout = ~x & y;
endmodule

module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;

  // First stage forms a - b, second stage subtracts the incoming borrow.
  half_sub u_hs0 (.x(a),  .y(b),   .d(d1), .bout(b1));
  half_sub u_hs1 (.x(d1), .y(bin), .d(d),  .bout(b2));

  assign bout = b1 | b2;
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller. Feeds one full-subtractor slice
// LSB first over WIDTH cycles with a registered borrow; start/done handshake.
// Handshake: start is sampled only in IDLE; the accepting edge captures a/b.
// busy is high for the WIDTH RUN cycles, done pulses for exactly one cycle,
// and diff/borrow(/ovf) hold the last result until the next completion.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int               CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic             bor_q, busy_q, done_q, borrow_q;

  logic             d_bit, bout_bit;
  logic [WIDTH-1:0] res_d;
  logic             accept, finish;

  full_sub_bit u_slice (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (bor_q),
    .d   (d_bit),
    .bout(bout_bit)
  );

  // New difference bit enters from the MSB side so the LSB lands at bit 0.
  assign res_d  = {d_bit, res_q[WIDTH-1:1]};
  assign accept = (state_q == ST_IDLE) && start;
  assign finish = (state_q == ST_RUN) && (cnt_q == LAST);

  // Control FSM, operand/result shifting and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bor_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= '0;
            bor_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q <= res_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          bor_q <= bout_bit;
          if (cnt_q == LAST) begin
            diff_q   <= res_d;
            borrow_q <= bout_bit;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic sign_a_q, sign_b_q, ovf_q;

  // Capture operand signs on accept; resolve overflow as the last bit completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        sign_a_q <= a[WIDTH-1];
        sign_b_q <= b[WIDTH-1];
      end
      if (finish) begin
        ovf_q <= (sign_a_q ^ sign_b_q) & (sign_a_q ^ d_bit);
      end
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_accept;
  assign unused_accept = accept ^ finish;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed + randomized bench for serial_sub_ctrl (WIDTH=8). Expected results
// come from plain arithmetic on the operands; timing expectations come from
// the documented start-to-done latency and op spacing.
`timescale 1ns/1ps
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] prev_diff;
  logic         prev_borrow;
  logic         prev_ovf;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular subtraction, unsigned compare, signed range test.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       output logic [W-1:0] ed, output logic eb, output logic eo);
    int sa, sb, sd;
    ed = ta - tb;
    eb = (ta < tb);
    sa = $signed(ta);
    sb = $signed(tb);
    sd = sa - sb;
    eo = (sd > 127) || (sd < -128);
  endtask

  // Runs one op; caller must be just after a negedge. Returns just after the
  // negedge following the DONE cycle, i.e. one cycle before the next legal accept.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input bit hold_start, input bit perturb);
    logic [W-1:0] ed;
    logic         eb, eo;
    model(ta, tb, ed, eb, eo);
    a = ta;
    b = tb;
    start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < W; c++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      if (perturb) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      check("busy_run", 32'(busy), 32'd1);
      check("done_run", 32'(done), 32'd0);
      check("diff_hold", 32'(diff), 32'(prev_diff));
      check("borrow_hold", 32'(borrow), 32'(prev_borrow));
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("diff", 32'(diff), 32'(ed));
    check("borrow", 32'(borrow), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", 32'(ovf), 32'(eo));
    prev_ovf = eo;
`endif
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("diff_after", 32'(diff), 32'(ed));
    prev_diff   = ed;
    prev_borrow = eb;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    prev_diff = '0;
    prev_borrow = 1'b0;
    prev_ovf = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_op(8'd5, 8'd8, 1'b0, 1'b0);
    do_op(8'd200, 8'd55, 1'b0, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 1'b0);
    do_op(8'hA5, 8'hA5, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 1'b0);
    do_op(8'h10, 8'h01, 1'b0, 1'b0);
    do_op(8'h7F, 8'hFF, 1'b0, 1'b0);

    // start held high across back-to-back ops with operands scrambled mid-RUN.
    do_op(8'h3C, 8'h5A, 1'b1, 1'b1);
    do_op(8'hF0, 8'h0F, 1'b1, 1'b1);
    start = 1'b0;
    @(negedge clk);
    check("idle_no_done", 32'(done), 32'd0);
    check("idle_no_busy", 32'(busy), 32'd0);

    // Reset in RUN cycle 4 aborts the op and clears all outputs.
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    @(posedge clk);
    repeat (4) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("abort_ovf", 32'(ovf), 32'd0);
`endif
    prev_diff = '0;
    prev_borrow = 1'b0;
    prev_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    do_op(8'h34, 8'h12, 1'b0, 1'b0);

    // Randomized operands, some back-to-back with start held.
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom_range(0, 255));
      do_op(ra, rb, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
      start = 1'b0;
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
